// File: rtl/midi_tx_queue.sv
// MIDI OUT transmitter. A message FIFO feeds a 31250-baud UART serialiser; bit timing is counted on clk.
// Optional feature macro: MIDI_TX_RUNNING_STATUS_EN (running-status compression of repeated channel status).
module midi_tx_queue #(
  parameter int CLKS_PER_BIT = 3200,
  parameter int DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_status,
  input  logic [7:0]             cmd_data1,
  input  logic [7:0]             cmd_data2,
  input  logic [1:0]             cmd_len,
  output logic                   midi_tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [1:0]             dbg_state
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Entry layout: {status[25:18], data1[17:10], data2[9:2], len[1:0]}
  logic [25:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;

  state_t        state_q;
  logic [CW-1:0] cyc_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [15:0]   rem_q;
  logic [1:0]    rem_cnt_q;
  logic          tx_q;
`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0]    last_status_q;
`endif

  logic        push, pop, bit_end;
  logic [25:0] head;
  logic [7:0]  ld_first;
  logic [15:0] ld_rem;
  logic [1:0]  ld_cnt;
  logic        ld_none;

  // Handshake: a message transfers on a rising clk edge where cmd_valid && cmd_ready.
  // cmd_ready depends only on the registered count, so a pop in the same cycle never frees room for a push.
  assign cmd_ready  = (count_q != (PW+1)'(DEPTH));
  assign push       = cmd_valid && cmd_ready && (cmd_len != 2'd0);
  assign bit_end    = (cyc_q == CW'(CLKS_PER_BIT - 1));
  assign pop        = (count_q != '0) &&
                      ((state_q == IDLE) || (state_q == STOP && bit_end && rem_cnt_q == 2'd0));
  assign head       = mem_q[rd_ptr_q];
  assign midi_tx    = tx_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;
  assign dbg_state  = state_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Byte list of the message at the FIFO head: first byte plus up to two remaining bytes.
  always_comb begin
    ld_first = head[25:18];
    ld_rem   = {head[9:2], head[17:10]};
    ld_cnt   = head[1:0] - 2'd1;
    ld_none  = 1'b0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (head[25:18] >= 8'h80 && head[25:18] <= 8'hEF && head[25:18] == last_status_q) begin
      ld_first = head[17:10];
      ld_rem   = {8'h00, head[9:2]};
      ld_cnt   = head[1:0] - 2'd2;
      ld_none  = (head[1:0] == 2'd1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_status, cmd_data1, cmd_data2, cmd_len};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rem_q     <= '0;
      rem_cnt_q <= '0;
      tx_q      <= 1'b1;
`ifdef MIDI_TX_RUNNING_STATUS_EN
      last_status_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: ;
        START: begin
          if (bit_end) begin
            cyc_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (rem_cnt_q != 2'd0) begin
              shift_q   <= rem_q[7:0];
              rem_q     <= {8'h00, rem_q[15:8]};
              rem_cnt_q <= rem_cnt_q - 1'b1;
              tx_q      <= 1'b0;
              state_q   <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A pop overrides the IDLE/STOP decision above and starts the next message immediately.
      if (pop) begin
        if (ld_none) begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end else begin
          state_q   <= START;
          tx_q      <= 1'b0;
          shift_q   <= ld_first;
          rem_q     <= ld_rem;
          rem_cnt_q <= ld_cnt;
        end
`ifdef MIDI_TX_RUNNING_STATUS_EN
        if (head[25:18] >= 8'h80 && head[25:18] <= 8'hEF) last_status_q <= head[25:18];
        else if (head[25:18] >= 8'hF0 && head[25:18] <= 8'hF7) last_status_q <= 8'h00;
`endif
      end
    end
  end
endmodule

// File: tb/tb_midi_tx_queue.sv
// Bench for midi_tx_queue: randomized and directed messages, a UART-decoding monitor and a byte scoreboard.
module tb_midi_tx_queue;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_status = '0, cmd_data1 = '0, cmd_data2 = '0;
  logic [1:0] cmd_len = '0;
  logic       cmd_ready, midi_tx, busy;
  logic [2:0] fifo_count;
  logic [1:0] dbg_state;

  midi_tx_queue #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_status(cmd_status), .cmd_data1(cmd_data1), .cmd_data2(cmd_data2), .cmd_len(cmd_len),
    .midi_tx(midi_tx), .busy(busy), .fifo_count(fifo_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_tests = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int         start_cyc_q[$];
  int         lo_cnt = 0, rx_bytes = 0, acc_cyc = 0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] m_last = 8'h00;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the bytes a message should produce on the wire.
  task automatic model_push(input logic [7:0] s, d1, d2, input logic [1:0] len);
    logic [7:0] b [3];
    int first;
    b[0] = s; b[1] = d1; b[2] = d2;
    first = 0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (len != 0) begin
      if (s >= 8'h80 && s <= 8'hEF && s == m_last) first = 1;
      if (s >= 8'h80 && s <= 8'hEF) m_last = s;
      else if (s >= 8'hF0 && s <= 8'hF7) m_last = 8'h00;
    end
`endif
    for (int i = first; i < int'(len); i++) exp_q.push_back(b[i]);
  endtask

  // ---------------- monitor: UART decoder sampling bit centres ----------------
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = '0;
  always @(negedge clk) begin
    if (!rst) begin
      rx_active = 1'b0;
      rx_cnt    = 0;
    end else begin
      if (!midi_tx) lo_cnt++;
      if (!rx_active) begin
        if (!midi_tx) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
          start_cyc_q.push_back(cyc);
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == CPB/2) check("rx_start_bit", midi_tx, 1'b0);
        else if (rx_cnt > CPB/2 && rx_cnt < 9*CPB + CPB/2 && (rx_cnt - CPB/2) % CPB == 0)
          rx_sh = {midi_tx, rx_sh[7:1]};
        else if (rx_cnt == 9*CPB + CPB/2) begin
          check("rx_stop_bit", midi_tx, 1'b1);
          rx_active = 1'b0;
          rx_bytes++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_unexpected_byte: got 0x%0h, no byte expected", rx_sh);
          end else begin
            check("rx_byte", rx_sh, exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Caller is just after a posedge; returns #1 after the accepting edge with cmd_valid still high.
  task automatic send(input logic [7:0] s, d1, d2, input logic [1:0] len);
    int n = 0;
    cmd_valid = 1'b1; cmd_status = s; cmd_data1 = d1; cmd_data2 = d2; cmd_len = len;
    @(negedge clk);
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("send_ready_timeout", cmd_ready, 1'b1);
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    model_push(s, d1, d2, len);
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || busy || rx_active) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pending_bytes"}, exp_q.size(), 0);
    check({name, "_busy"}, busy, 1'b0);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] rand_status();
    case ($urandom_range(0, 6))
      0, 1:    return 8'h90;
      2:       return 8'hB0;
      3:       return 8'hF0 | 8'($urandom_range(0, 7));
      4:       return 8'hF8 | 8'($urandom_range(0, 7));
      5:       return 8'($urandom_range(0, 127));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n, lo0, b0, busy_cyc;
    repeat (3) @(negedge clk);
    check("reset_midi_tx", midi_tx, 1'b1);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_fifo_count", fifo_count, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single 3-byte message from idle: timing of first fall, byte spacing, busy drop.
    start_cyc_q.delete();
    send(8'hB0, 8'h2E, 8'h7F, 2'd3);
    cmd_valid = 1'b0;
    check("t1_count_after_accept", fifo_count, 1);
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    busy_cyc = cyc;
    check("t1_start_count", start_cyc_q.size(), 3);
    if (start_cyc_q.size() >= 3) begin
      check("t1_first_fall", start_cyc_q[0] - acc_cyc, 1);
      check("t1_byte1_spacing", start_cyc_q[1] - start_cyc_q[0], 10*CPB);
      check("t1_byte2_spacing", start_cyc_q[2] - start_cyc_q[1], 10*CPB);
      check("t1_busy_drop", busy_cyc - start_cyc_q[0], 30*CPB);
    end
    drain("t1", 2000);

    // Back-to-back fill with cmd_valid held high.
    start_cyc_q.delete();
    for (int i = 0; i < 5; i++) send(8'hC0, 8'h42, 8'h00, 2'd2);
    check("t2_full_count", fifo_count, 4);
    check("t2_full_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    n = 0;
    while (fifo_count == 3'd4 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("t2_count_after_pop", fifo_count, 3);
    check("t2_ready_after_pop", cmd_ready, 1'b1);
    drain("t2", 5000);
    check("t2_byte_count", start_cyc_q.size(), 10);
    if (start_cyc_q.size() == 10)
      check("t2_no_gaps", start_cyc_q[9] - start_cyc_q[0], 9*10*CPB);

    // Zero-length message: accepted, not stored, silent.
    lo0 = lo_cnt;
    send(8'h90, 8'h3C, 8'h40, 2'd0);
    cmd_valid = 1'b0;
    check("t3_count", fifo_count, 0);
    check("t3_busy", busy, 1'b0);
    repeat (500) @(negedge clk);
    check("t3_line_quiet", lo_cnt - lo0, 0);
    check("t3_midi_tx", midi_tx, 1'b1);
    @(posedge clk); #1;

    // Reset during DATA of the second byte with two messages queued.
    b0 = rx_bytes;
    send(8'hA0, 8'h01, 8'h02, 2'd3);
    send(8'hA1, 8'h03, 8'h04, 2'd3);
    send(8'hA2, 8'h05, 8'h06, 2'd3);
    cmd_valid = 1'b0;
    n = 0;
    while (rx_bytes == b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (5*CPB) @(negedge clk);
    check("t4_queued_before_reset", fifo_count, 2);
    #2 rst = 1'b0;
    #1;
    check("t4_reset_midi_tx", midi_tx, 1'b1);
    check("t4_reset_count", fifo_count, 0);
    check("t4_reset_busy", busy, 1'b0);
    exp_q.delete();
`ifdef MIDI_TX_RUNNING_STATUS_EN
    m_last = 8'h00;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b1;
    lo0 = lo_cnt;
    b0 = rx_bytes;
    repeat (500) @(negedge clk);
    check("t4_quiet_lows", lo_cnt - lo0, 0);
    check("t4_quiet_bytes", rx_bytes - b0, 0);
    @(posedge clk); #1;
    send(8'h80, 8'h11, 8'h22, 2'd3);
    cmd_valid = 1'b0;
    drain("t4", 2000);

    // Running-status sequence (expected bytes depend on the build).
    send(8'h90, 8'h3C, 8'h40, 2'd3);
    send(8'h90, 8'h3E, 8'h40, 2'd3);
    send(8'hF8, 8'h00, 8'h00, 2'd1);
    send(8'h90, 8'h40, 8'h40, 2'd3);
    cmd_valid = 1'b0;
    drain("t5", 6000);

    // Randomized messages with random gaps.
    for (int i = 0; i < 40; i++) begin
      send(rand_status(), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           2'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(0, 400)) @(negedge clk);
        @(posedge clk); #1;
      end
    end
    cmd_valid = 1'b0;
    drain("t6", 30000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
